// File: rtl/wb_pkg.sv
// Shared writeback types: default register widths and the buffered
// multi-cycle result entry.
package wb_pkg;
    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback-side bundle: pipeline W-stage result, multi-cycle result
// handshake, register-file write port and hazard-unit stall request.
interface wb_port_arbiter_if
    import wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DEPTH  = 2
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              RegWriteW;
    logic [ADDR_W-1:0] RdW;
    logic [DATA_W-1:0] ResultW;
    logic              mc_valid;
    logic              mc_ready;
    logic [ADDR_W-1:0] mc_rd;
    logic [DATA_W-1:0] mc_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              stall_req;
    logic [CNT_W-1:0]  fifo_count;

    modport slave (
        input  RegWriteW, RdW, ResultW, mc_valid, mc_rd, mc_data,
        output mc_ready, rf_we, rf_waddr, rf_wdata, stall_req, fifo_count
    );

    modport master (
        output RegWriteW, RdW, ResultW, mc_valid, mc_rd, mc_data,
        input  mc_ready, rf_we, rf_waddr, rf_wdata, stall_req, fifo_count
    );
endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback entries; push into a full FIFO and
// pop from an empty one are ignored.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                wrEntry,
    output wb_entry_t                rdEntry,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic             doPush, doPop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign doPush  = push && !full;
    assign doPop   = pop && !empty;
    assign rdEntry = mem[rdPtr];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PTR_W'(1);
            if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= wrEntry;
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the W-stage writeback and
// buffered multi-cycle results, requesting a bubble when buffered results starve.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_W   = WB_DATA_W,
    parameter int ADDR_W   = WB_ADDR_W,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input logic clk,
    input logic rst,
    wb_port_arbiter_if.slave wb
);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    wb_entry_t         pushEntry, headEntry;
    logic              pipeHit, push, pop, full, empty;
    logic [CNT_W-1:0]  count;
    logic [WAIT_W-1:0] waitCnt;

    assign pipeHit   = wb.RegWriteW && (wb.RdW != '0);
    // Ready comes from registered occupancy only: a same-cycle pop never frees a slot early.
    assign wb.mc_ready = !full && !rst;
    // x0 results complete the handshake but are dropped.
    assign push      = wb.mc_valid && wb.mc_ready && (wb.mc_rd != '0);
    assign pop       = !rst && !pipeHit && !empty;
    assign pushEntry = '{rd: wb.mc_rd, data: wb.mc_data};

    wb_fifo #(.DEPTH(DEPTH)) uFifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wrEntry (pushEntry),
        .rdEntry (headEntry),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Pipeline has fixed priority; the FIFO head only fills otherwise idle slots.
    always_comb begin
        wb.rf_we    = 1'b0;
        wb.rf_waddr = '0;
        wb.rf_wdata = '0;
        if (!rst && pipeHit) begin
            wb.rf_we    = 1'b1;
            wb.rf_waddr = wb.RdW;
            wb.rf_wdata = wb.ResultW;
        end else if (pop) begin
            wb.rf_we    = 1'b1;
            wb.rf_waddr = headEntry.rd;
            wb.rf_wdata = headEntry.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            waitCnt <= '0;
        else if (empty || pop)
            waitCnt <= '0;
        else if (waitCnt != WAIT_W'(MAX_WAIT))
            waitCnt <= waitCnt + WAIT_W'(1);
    end

    assign wb.stall_req  = (waitCnt == WAIT_W'(MAX_WAIT)) || full;
    assign wb.fifo_count = count;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed and random checks of wb_port_arbiter against a queue-based model.
module tb_wb_port_arbiter;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // Reference model: buffered results in arrival order plus a starvation count.
    logic [4:0]  qRd[$];
    logic [31:0] qData[$];
    int          mWait = 0;

    wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH)) bus ();

    wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compareAll(input string tag);
        logic        pipeHit, eWe;
        logic [4:0]  eAddr;
        logic [31:0] eData;
        pipeHit = bus.RegWriteW && bus.RdW != 5'd0;
        eWe = 1'b0; eAddr = '0; eData = '0;
        if (pipeHit) begin
            eWe = 1'b1; eAddr = bus.RdW; eData = bus.ResultW;
        end else if (qRd.size() > 0) begin
            eWe = 1'b1; eAddr = qRd[0]; eData = qData[0];
        end
        check({tag, ".rf_we"},      64'(bus.rf_we),      64'(eWe));
        check({tag, ".rf_waddr"},   64'(bus.rf_waddr),   64'(eAddr));
        check({tag, ".rf_wdata"},   64'(bus.rf_wdata),   64'(eData));
        check({tag, ".mc_ready"},   64'(bus.mc_ready),   64'(qRd.size() < DEPTH));
        check({tag, ".stall_req"},  64'(bus.stall_req),  64'(mWait == MAX_WAIT || qRd.size() == DEPTH));
        check({tag, ".fifo_count"}, 64'(bus.fifo_count), 64'(qRd.size()));
    endtask

    task automatic modelStep();
        logic pipeHit, popNow, pushNow;
        pipeHit = bus.RegWriteW && bus.RdW != 5'd0;
        popNow  = !pipeHit && qRd.size() > 0;
        pushNow = bus.mc_valid && qRd.size() < DEPTH && bus.mc_rd != 5'd0;
        if (qRd.size() > 0 && !popNow) mWait = (mWait < MAX_WAIT) ? mWait + 1 : MAX_WAIT;
        else mWait = 0;
        if (popNow) begin void'(qRd.pop_front()); void'(qData.pop_front()); end
        if (pushNow) begin qRd.push_back(bus.mc_rd); qData.push_back(bus.mc_data); end
    endtask

    // Drive at posedge+1, compare at the falling edge, advance model on the rising edge.
    task automatic cycle(input string tag, input logic rw, input logic [4:0] rd, input logic [31:0] res,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        bus.RegWriteW = rw; bus.RdW = rd; bus.ResultW = res;
        bus.mc_valid = mv; bus.mc_rd = mrd; bus.mc_data = md;
        #4;
        compareAll(tag);
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkResetZeros(input string tag);
        check({tag, ".rf_we"},      64'(bus.rf_we),      64'd0);
        check({tag, ".mc_ready"},   64'(bus.mc_ready),   64'd0);
        check({tag, ".stall_req"},  64'(bus.stall_req),  64'd0);
        check({tag, ".fifo_count"}, 64'(bus.fifo_count), 64'd0);
    endtask

    initial begin
        bus.RegWriteW = 1'b1; bus.RdW = 5'd6; bus.ResultW = 32'h1;
        bus.mc_valid = 1'b1; bus.mc_rd = 5'd8; bus.mc_data = 32'h2;
        #2;
        checkResetZeros("reset0");
        @(posedge clk); #1;
        rst = 1'b0;

        cycle("pipeWrite", 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        cycle("mcPush7",   1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12);
        cycle("mcRetire7", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        cycle("mcDone7",   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Starvation under continuous pipeline writes.
        cycle("starvePush", 1'b1, 5'd3, 32'hA0, 1'b1, 5'd9, 32'h99);
        for (int i = 0; i < 5; i++) cycle("starve", 1'b1, 5'd3, 32'hA1 + i, 1'b0, 5'd0, 32'h0);
        check("stallHigh", 64'(bus.stall_req), 64'd1);
        cycle("bubble", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        cycle("afterBubble", 1'b1, 5'd3, 32'hB0, 1'b0, 5'd0, 32'h0);

        // Fill to full, hold a third result until a slot frees.
        cycle("fillA", 1'b1, 5'd3, 32'hC0, 1'b1, 5'd10, 32'hAAAA);
        cycle("fillB", 1'b1, 5'd3, 32'hC1, 1'b1, 5'd11, 32'hBBBB);
        for (int i = 0; i < 3; i++) cycle("fullHold", 1'b1, 5'd3, 32'hC2, 1'b1, 5'd12, 32'hCCCC);
        check("fullCount", 64'(bus.fifo_count), 64'd2);
        cycle("popWhileFull", 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hCCCC);
        for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 5'd0, 32'h0, i == 0, 5'd12, 32'hCCCC);

        // x0 behaviour on both streams.
        cycle("push4",    1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44);
        cycle("pipeX0",   1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'h0);
        cycle("mcX0",     1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h55);
        cycle("afterX0",  1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Reset mid-stream with two buffered entries.
        cycle("preRstA", 1'b1, 5'd2, 32'hD0, 1'b1, 5'd13, 32'hD13);
        cycle("preRstB", 1'b1, 5'd2, 32'hD1, 1'b1, 5'd14, 32'hD14);
        check("preRstCount", 64'(bus.fifo_count), 64'd2);
        bus.RegWriteW = 1'b1; bus.RdW = 5'd2; bus.mc_valid = 1'b1; bus.mc_rd = 5'd15;
        rst = 1'b1;
        #1;
        checkResetZeros("midReset");
        qRd.delete(); qData.delete(); mWait = 0;
        @(posedge clk); #1;
        checkResetZeros("midResetEdge");
        rst = 1'b0;
        cycle("postRst", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        cycle("postRst2", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Random traffic; a hazard unit mostly answers stall_req with a bubble.
        for (int i = 0; i < 400; i++) begin
            logic rw;
            logic stallExp;
            stallExp = (mWait == MAX_WAIT) || (qRd.size() == DEPTH);
            rw = (stallExp && $urandom_range(0, 3) != 0) ? 1'b0 : ($urandom_range(0, 2) != 0);
            cycle("random", rw, 5'($urandom_range(0, 31)) & {5{$urandom_range(0, 7) != 0}},
                  $urandom, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 31)) & {5{$urandom_range(0, 7) != 0}}, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback (ResultW from the W stage) and a multi-cycle execution unit (divider / long-latency load) that returns results out of band. Multi-cycle results are buffered in a small FIFO and retired into free write-port slots. A wait counter raises a stall request to the hazard unit when buffered results are starved. Sits between WriteBack_Cycle and the register file, alongside the hazard unit.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- DEPTH, 2, multi-cycle result FIFO entries (power of two, ≥2)
- MAX_WAIT, 4, consecutive starved cycles before stall_req (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- RegWriteW  in  1  pipeline writeback valid
- RdW  in  ADDR_W  pipeline destination register
- ResultW  in  DATA_W  pipeline writeback data
- mc_valid  in  1  multi-cycle result valid
- mc_ready  out  1  multi-cycle result accepted this cycle when high with mc_valid
- mc_rd  in  ADDR_W  multi-cycle destination register
- mc_data  in  DATA_W  multi-cycle result data
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- stall_req  out  1  request to hazard unit to insert a W-stage bubble
- fifo_count  out  clog2(DEPTH)+1  occupied entries (debug/verification)

## Operation
- pipe_hit = RegWriteW && RdW != 0. Writes to x0 never assert rf_we.
- Port grant, fixed priority: pipe_hit → pipeline drives rf_*; else FIFO non-empty → head drives rf_*, head popped same edge; else rf_we=0, rf_waddr/rf_wdata = 0.
- Push: mc_valid && mc_ready at edge. mc_rd == 0 → handshake completes, nothing stored.
- mc_ready = !full, from registered count only. No push into a full FIFO even when a pop occurs that cycle.
- Simultaneous push and pop (not full): count unchanged, head advances, new entry at tail.
- A pushed entry is never written to RF in the cycle of its push. No mc→RF bypass.
- wait_cnt: increments (saturating at MAX_WAIT) each cycle FIFO non-empty and no pop; clears on any pop or when FIFO empty.
- stall_req = (wait_cnt == MAX_WAIT) || full; registered-state derived only, glitch-free. Stays high until a pop clears the condition. The hazard unit answers by forcing RegWriteW=0 the following cycle.
- Same rd from pipeline and FIFO head in one cycle: pipeline writes, head waits. Ordering between the two streams is the scoreboard's responsibility, not this block's.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.

## Timing
- Reset (async, immediate): count=0, pointers=0, wait_cnt=0. While rst is high, rf_we=0, mc_ready=0, stall_req=0, fifo_count=0.
- Pipeline path is combinational: RegWriteW→rf_we in the same cycle, zero latency.
- Multi-cycle path: minimum 1 cycle from the push edge to rf_we, if no pipe_hit.
- stall_req asserts the cycle after the edge on which wait_cnt reaches MAX_WAIT or count reaches DEPTH.
- Reset mid-operation discards all buffered entries. Deassertion resumes with an empty FIFO on the next edge.

## Structure
- Shared package wb_pkg: DATA_W, ADDR_W defaults; wb_entry_t {rd[ADDR_W], data[DATA_W]}.
- Sub-module wb_fifo: synchronous FIFO of wb_entry_t with push/pop/full/empty/count and async active-high reset. The arbiter holds grant logic and wait_cnt.

## Test plan
- Reset pulse mid-stream with 2 entries buffered → all outputs 0 during rst. After release, fifo_count=0, mc_ready=1, no RF write of stale entries.
- RegWriteW=1, RdW=5, ResultW=0xDEADBEEF, FIFO empty → same cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- mc push rd=7, data=0x12 with RegWriteW=0 → next cycle rf_we=1, rf_waddr=7, rf_wdata=0x12, fifo_count returns to 0.
- Pipeline writes rd=3 every cycle while mc pushes rd=9 → entry held. stall_req rises after 4 starved cycles. One bubble (RegWriteW=0) → rd=9 written, stall_req falls next cycle.
- Two mc pushes under continuous pipe_hit → fifo_count=2, mc_ready=0, stall_req=1. Third mc_valid held until a pop. No entry lost, writes in FIFO order.
- Pipeline writes x0 while FIFO holds rd=4 → rf_we=1 for rd=4 (FIFO uses the slot). mc push with mc_rd=0 → accepted, fifo_count unchanged.
